// File: rtl/k2_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// k2_ctrl_pkg
// Shared types and sizes for the K2 run controller.
//   state_t    : run lifecycle states (IDLE, RUN, DONE)
//   PROG_DEPTH : number of instruction words in the program RAM
//   INST_W     : instruction word width
//   PC_W       : width of the core program address
// -----------------------------------------------------------------------------
package k2_ctrl_pkg;

  localparam int PROG_DEPTH = 16;
  localparam int INST_W     = 8;
  localparam int PC_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : k2_ctrl_pkg

// File: rtl/k2_result_fifo.sv
// -----------------------------------------------------------------------------
// k2_result_fifo
// Synchronous show-ahead FIFO that buffers core results for the consumer.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise the caller is expected to treat the value as dropped.
//
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset, empties the FIFO
//   i_push       : write request
//   i_push_data  : data to write
//   i_pop        : read request, ignored while empty
//   o_full       : FIFO holds FIFO_DEPTH entries
//   o_empty      : FIFO holds no entries
//   o_head       : oldest entry, valid whenever o_empty is low
// -----------------------------------------------------------------------------
module k2_result_fifo #(
  parameter int BITS       = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic [BITS-1:0] i_push_data,
  input  logic            i_pop,
  output logic            o_full,
  output logic            o_empty,
  output logic [BITS-1:0] o_head
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic w_do_pop;
  logic w_do_push;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CW'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];

  // A pop frees the slot the push needs, so full-with-pop still accepts.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before the edge, independent of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= ptr_inc(r_wptr);
      if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; the pointers and count alone define
  // which entries are meaningful, and leaving the array unreset lets it map
  // onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_push_data;
  end

endmodule : k2_result_fifo

// File: rtl/k2_run_controller.sv
// -----------------------------------------------------------------------------
// k2_run_controller
// Owns the K2 instruction RAM and run lifecycle. A 16-word program is loaded
// over a valid/ready port, the core is released from reset on start, run for
// MAX_CYCLES cycles, and every change of its Ro output is queued in a result
// FIFO for a downstream consumer.
//
// Build option:
//   K2_HALT_DETECT_EN : when defined, a run also ends when core_pc repeats
//                       its previous-cycle value (self-jump), and the
//                       'halted' output reports that termination cause.
//
// Ports:
//   clk, rst               : clock and synchronous active-high reset
//   load_valid/data/last   : program word stream; load_ready accepts
//   start                  : pulse to begin a run with a valid program
//   busy / done            : in RUN / in DONE
//   overflow               : sticky, a result was dropped on a full FIFO
//   core_rst_n             : active-low reset to the core
//   core_pc / core_inst    : fetch address in, instruction out (async read)
//   core_ro                : core result output
//   res_valid/data/ready   : show-ahead result FIFO read port
//   halted                 : (K2_HALT_DETECT_EN only) run ended by self-jump
// -----------------------------------------------------------------------------
module k2_run_controller
  import k2_ctrl_pkg::*;
#(
  parameter int BITS       = 8,
  parameter int MAX_CYCLES = 255,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [INST_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              core_rst_n,
  input  logic [PC_W-1:0]   core_pc,
  output logic [INST_W-1:0] core_inst,
  input  logic [BITS-1:0]   core_ro,
  output logic              res_valid,
  output logic [BITS-1:0]   res_data,
  input  logic              res_ready
`ifdef K2_HALT_DETECT_EN
  ,
  output logic              halted
`endif
);

  // Wide enough to hold MAX_CYCLES-1 even when MAX_CYCLES is 1.
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  state_t            r_state;
  state_t            w_next;

  logic [INST_W-1:0] r_mem [PROG_DEPTH];
  logic [PC_W-1:0]   r_wptr;
  logic              r_prog_valid;

  logic [CNT_W-1:0]  r_cycle;
  logic [BITS-1:0]   r_last_ro;
  logic              r_overflow;
  logic              r_done;
  logic              r_core_rst_n;

  logic              w_load_ready;
  logic              w_busy;
  logic              w_load_fire;
  logic              w_start_ok;
  logic              w_enter_run;
  logic              w_budget;
  logic              w_term;
  logic              w_ro_change;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_drop;

`ifdef K2_HALT_DETECT_EN
  logic [PC_W-1:0]   r_prev_pc;
  logic              r_pc_armed;
  logic              r_halted;
  logic              w_halt;
`endif

  // ---------------------------------------------------------------------------
  // Handshake and termination decode
  // ---------------------------------------------------------------------------
  assign w_load_fire = load_valid && w_load_ready;
  // A word accepted this cycle may invalidate the program, so it wins over start.
  assign w_start_ok  = start && r_prog_valid && !w_load_fire;
  assign w_budget    = (r_cycle == CNT_W'(MAX_CYCLES - 1));

`ifdef K2_HALT_DETECT_EN
  // r_pc_armed masks the first RUN cycle, whose previous pc is stale.
  assign w_halt = r_pc_armed && (core_pc == r_prev_pc);
  assign w_term = w_budget || w_halt;
`else
  assign w_term = w_budget;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and combinational outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next       = r_state;
    w_load_ready = 1'b1;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_ok) w_next = RUN;
      end
      RUN: begin
        w_load_ready = 1'b0;
        w_busy       = 1'b1;
        if (w_term) w_next = DONE;
      end
      DONE: begin
        if (w_load_fire)     w_next = IDLE;
        else if (w_start_ok) w_next = RUN;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_enter_run = (w_next == RUN) && (r_state != RUN);

  // ---------------------------------------------------------------------------
  // Registered run outputs: follow the next state so they line up with it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done       <= 1'b0;
      r_core_rst_n <= 1'b0;
    end else begin
      r_done       <= (w_next == DONE);
      r_core_rst_n <= (w_next == RUN);
    end
  end

  // ---------------------------------------------------------------------------
  // Program load
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr       <= '0;
      r_prog_valid <= 1'b0;
    end else if (w_load_fire) begin
      r_wptr       <= load_last ? '0 : r_wptr + 1'b1;
      r_prog_valid <= load_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_load_fire) r_mem[r_wptr] <= load_data;
  end

  assign core_inst = r_mem[core_pc];

  // ---------------------------------------------------------------------------
  // Run budget and result change detection
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle <= '0;
    end else if (w_enter_run) begin
      r_cycle <= '0;
    end else if (r_state == RUN) begin
      r_cycle <= r_cycle + 1'b1;
    end
  end

  assign w_ro_change = (r_state == RUN) && (core_ro != r_last_ro);
  // Full implies non-empty, so res_ready alone tells whether a pop frees a slot.
  assign w_drop      = w_ro_change && w_fifo_full && !res_ready;

  // last_ro tracks every change, including dropped ones, so a dropped value
  // is not re-offered on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_ro  <= '0;
      r_overflow <= 1'b0;
    end else if (w_enter_run) begin
      r_last_ro  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_ro_change) r_last_ro  <= core_ro;
      if (w_drop)      r_overflow <= 1'b1;
    end
  end

`ifdef K2_HALT_DETECT_EN
  // ---------------------------------------------------------------------------
  // Self-jump detection
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_pc  <= '0;
      r_pc_armed <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_prev_pc  <= core_pc;
      r_pc_armed <= (r_state == RUN) && (w_next == RUN);
      if (w_next != DONE)      r_halted <= 1'b0;
      else if (r_state == RUN) r_halted <= w_halt;
    end
  end

  assign halted = r_halted;
`endif

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  k2_result_fifo #(
    .BITS       (BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_ro_change),
    .i_push_data (core_ro),
    .i_pop       (res_ready),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_head      (res_data)
  );

  // ---------------------------------------------------------------------------
  // Port drives
  // ---------------------------------------------------------------------------
  assign load_ready = w_load_ready;
  assign busy       = w_busy;
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign core_rst_n = r_core_rst_n;
  assign res_valid  = !w_fifo_empty;

endmodule : k2_run_controller

// File: tb/tb_k2_run_controller.sv
// -----------------------------------------------------------------------------
// tb_k2_run_controller
// Self-checking bench for k2_run_controller (default parameters). Results
// expected from the FIFO are queued as core_ro is driven and compared as the
// consumer pops them. Halt-detect checks follow K2_HALT_DETECT_EN.
// -----------------------------------------------------------------------------
module tb_k2_run_controller;

  localparam int BITS = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            load_valid;
  logic [7:0]      load_data;
  logic            load_last;
  logic            load_ready;
  logic            start;
  logic            busy;
  logic            done;
  logic            overflow;
  logic            core_rst_n;
  logic [3:0]      core_pc;
  logic [7:0]      core_inst;
  logic [BITS-1:0] core_ro;
  logic            res_valid;
  logic [BITS-1:0] res_data;
  logic            res_ready;
`ifdef K2_HALT_DETECT_EN
  logic            halted;
`endif

  int              n_checks = 0;
  int              n_fail   = 0;
  logic [BITS-1:0] exp_q [$];
  logic [BITS-1:0] mon_exp;
  logic [BITS-1:0] model_last;
  logic [BITS-1:0] fib_seq [8];

  typedef struct {
    logic [3:0] pc;
    logic [7:0] inst;
  } inst_vec_t;

  inst_vec_t vecs [16];

  always #5 clk = ~clk;

  k2_run_controller dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .core_rst_n (core_rst_n),
    .core_pc    (core_pc),
    .core_inst  (core_inst),
    .core_ro    (core_ro),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready)
`ifdef K2_HALT_DETECT_EN
    ,
    .halted     (halted)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_program(input logic [7:0] base, input logic with_start);
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1;
      load_data  = base + 8'(i);
      load_last  = (i == 15);
      start      = with_start && (i == 15);
      check("load_ready_during_load", load_ready, 1);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    start      = 1'b0;
  endtask

  // Consumer side of the scoreboard: a pop happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL res_unexpected: got 0x%0h, expected no entry", res_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("res_data", res_data, mon_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    start      = 1'b0;
    core_pc    = '0;
    core_ro    = '0;
    res_ready  = 1'b0;
    fib_seq    = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13};
    for (int i = 0; i < 16; i++) begin
      vecs[i].pc   = 4'(i);
      vecs[i].inst = 8'h10 + 8'(i);
    end

    // ---- reset state ----
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_load_ready", load_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_res_valid", res_valid, 0);

    // ---- start without a program is ignored ----
    start = 1'b1;
    tick();
    start = 1'b0;
    check("noprog_busy", busy, 0);
    check("noprog_core_rst_n", core_rst_n, 0);
    tick();
    check("noprog_busy_later", busy, 0);

    // ---- load and read back through the fetch port ----
    load_program(8'h10, 1'b0);
    for (int i = 0; i < 16; i++) begin
      core_pc = vecs[i].pc;
      #1;
      check("core_inst", core_inst, vecs[i].inst);
    end

    // wptr returned to 0: the next word lands in mem[0] and invalidates the program
    load_valid = 1'b1;
    load_data  = 8'hA5;
    load_last  = 1'b0;
    tick();
    load_valid = 1'b0;
    core_pc    = 4'd0;
    #1;
    check("wptr_wrapped_mem0", core_inst, 8'hA5);
    core_pc = 4'd1;
    #1;
    check("mem1_untouched", core_inst, 8'h11);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("partial_prog_start_ignored", busy, 0);

    // load and start in the same cycle: the load wins
    load_program(8'h10, 1'b1);
    check("load_beats_start_busy", busy, 0);
    check("load_beats_start_core_rst", core_rst_n, 0);

    // ---- run 1: fibonacci results, consumer always ready ----
    res_ready  = 1'b1;
    core_ro    = '0;
    model_last = '0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check("run_busy", busy, 1);
    check("run_core_rst_n", core_rst_n, 1);
    check("run_load_ready", load_ready, 0);
    for (int i = 0; i < 255; i++) begin
      core_pc = 4'(i);
      core_ro = (i < 8) ? fib_seq[i] : fib_seq[7];
      start   = (i == 100);
      if (core_ro != model_last) begin
        exp_q.push_back(core_ro);
        model_last = core_ro;
      end
      tick();
      start = 1'b0;
      if (i == 253) begin
        check("budget_last_cycle_busy", busy, 1);
        check("budget_last_cycle_done", done, 0);
      end
    end
    check("budget_done", done, 1);
    check("budget_busy", busy, 0);
    check("budget_core_rst_n", core_rst_n, 0);
    check("done_load_ready", load_ready, 1);
    check("fib_overflow", overflow, 0);
`ifdef K2_HALT_DETECT_EN
    check("budget_halted", halted, 0);
`endif
    repeat (3) tick();
    check("fib_all_popped", exp_q.size(), 0);
    check("fib_res_valid", res_valid, 0);

    // ---- run 2: stalled consumer, push+pop on full, then overflow ----
    core_ro = '0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check("run2_busy", busy, 1);
    for (int i = 0; i < 255; i++) begin
      core_pc = 4'(i);
      if (i < 4) begin
        core_ro   = 8'(21 + i);
        res_ready = 1'b0;
        exp_q.push_back(core_ro);
      end else if (i == 4) begin
        core_ro   = 8'd25;
        res_ready = 1'b1;
        exp_q.push_back(core_ro);
      end else if (i < 7) begin
        core_ro   = 8'(21 + i);
        res_ready = 1'b0;
      end else begin
        res_ready = 1'b1;
      end
      tick();
      if (i == 3) begin
        check("full_res_valid", res_valid, 1);
        check("full_no_overflow", overflow, 0);
      end
      if (i == 4) check("push_pop_on_full_no_overflow", overflow, 0);
      if (i == 5) check("drop_sets_overflow", overflow, 1);
      if (i == 20) begin
        check("drain_all_popped", exp_q.size(), 0);
        check("drain_res_valid", res_valid, 0);
      end
    end
    check("run2_done", done, 1);
    check("overflow_sticky_in_done", overflow, 1);

    // ---- run 3: reset in the middle of a run ----
    res_ready = 1'b0;
    core_ro   = '0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("overflow_cleared_on_run", overflow, 0);
    for (int i = 0; i < 10; i++) begin
      core_pc = 4'(i);
      core_ro = (i >= 2) ? 8'h40 : 8'h00;
      tick();
    end
    check("pre_rst_res_valid", res_valid, 1);
    rst     = 1'b1;
    core_pc = 4'd10;
    tick();
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_core_rst_n", core_rst_n, 0);
    check("midrun_rst_res_valid", res_valid, 0);
    check("midrun_rst_load_ready", load_ready, 1);
    rst     = 1'b0;
    core_ro = '0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_cleared_prog_valid", busy, 0);
    check("rst_cleared_prog_core_rst_n", core_rst_n, 0);

    // ---- run 4: self-jump at cycles 20/21 ----
    load_program(8'h30, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 255; i++) begin
      core_pc = (i == 20 || i == 21) ? 4'd7 : 4'(i);
      tick();
`ifdef K2_HALT_DETECT_EN
      if (i == 20) check("halt_not_yet", done, 0);
      if (i == 21) begin
        check("halt_done", done, 1);
        check("halt_halted", halted, 1);
        check("halt_busy", busy, 0);
        break;
      end
`else
      if (i == 21) check("no_halt_detect_done", done, 0);
      if (i == 253) check("no_halt_budget_not_yet", done, 0);
`endif
    end
`ifndef K2_HALT_DETECT_EN
    check("no_halt_budget_done", done, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_k2_run_controller

// File: doc/k2_run_controller.md
Name: k2_run_controller

Overview:
- Sequencer that owns the K2 processor's instruction memory and run lifecycle.
- Accepts a 16-word program over a valid/ready load port and stores it in an internal instruction RAM that feeds the core's fetch.
- Holds the core in reset until started, runs it to a cycle budget or halt, and buffers every change of the core's Ro output into a result FIFO for a downstream consumer.

Parameters:
- BITS, 8, width of core Ro and result data.
- MAX_CYCLES, 255, run budget in clock cycles (must be at least 1).
- FIFO_DEPTH, 4, result FIFO entries (power of two).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  program word valid.
- load_data  in  8  instruction word.
- load_last  in  1  marks final word of program.
- load_ready  out  1  controller accepts a word.
- start  in  1  single-cycle pulse to begin a run.
- busy  out  1  high while in RUN.
- done  out  1  high in DONE.
- overflow  out  1  sticky; a result was dropped.
- core_rst_n  out  1  drives K2 active-low reset.
- core_pc  in  4  K2 ProgramAddress.
- core_inst  out  8  instruction to K2, combinational read of mem[core_pc].
- core_ro  in  BITS  K2 Ro.
- res_valid  out  1  FIFO not empty.
- res_data  out  BITS  FIFO head.
- res_ready  in  1  consumer pops on res_valid && res_ready.

Behaviour:
- Reset values:
  - state is IDLE.
  - Outputs: load_ready=1, busy=0, done=0, overflow=0, core_rst_n=0, res_valid=0.
  - Internal: wptr=0, prog_valid=0, FIFO empty.
  - RAM contents are undefined after reset, and prog_valid=0.
- States: IDLE, RUN, DONE.
- Load (IDLE or DONE): load_ready=1.
  - On handshake, mem[wptr]<=load_data and wptr increments, wrapping at 16.
  - Handshake with load_last sets wptr=0 and prog_valid=1.
  - Handshake without load_last clears prog_valid.
  - Any handshake in DONE moves to IDLE and clears done.
- Start:
  - start in IDLE or DONE with prog_valid=1 moves to RUN next cycle.
  - start with prog_valid=0 is ignored.
  - A load handshake and start in the same cycle: the load wins and start is ignored.
- RUN:
  - core_rst_n=1, busy=1, load_ready=0.
  - The cycle counter clears on entry and increments each RUN cycle.
  - last_ro clears to 0 on entry.
  - Each RUN cycle, if core_ro != last_ro:
    - push core_ro into the FIFO and set last_ro<=core_ro;
    - if the FIFO is full and no pop occurs that cycle, drop the value, set overflow, and still update last_ro.
  - A simultaneous push and pop on a full FIFO is legal.
  - start during RUN is ignored.
- Termination:
  - When the counter reaches MAX_CYCLES-1, move to DONE.
  - In DONE, core_rst_n=0 and done=1, both registered and asserted the cycle after the transition.
- FIFO:
  - Pops are accepted in every state.
  - Cleared only by rst.
  - Read latency: res_data is valid in the same cycle as res_valid (show-ahead).
- Overflow clears only on rst or on the next RUN entry.
- rst mid-RUN: core is forced into reset on the next edge, FIFO contents are discarded, and prog_valid clears.

Optional Feature:
- Macro K2_HALT_DETECT_EN.
- Defined:
  - RUN also terminates when core_pc equals its previous-cycle value (a self-jump).
  - The comparison starts from the second RUN cycle.
  - Halt and budget expiry in the same cycle: a single transition to DONE.
  - Adds a halted output, 1 bit, set with done when termination was by halt, else 0.
- Undefined: only the budget terminates RUN, and the halted port is absent.

Decomposition:
- Package k2_ctrl_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - PROG_DEPTH=16, INST_W=8, PC_W=4.
- One sub-module, k2_result_fifo: parameterized BITS/FIFO_DEPTH, synchronous FIFO with full/empty, simultaneous push and pop.
- The instruction RAM and FSM stay in the top.

Test Plan:
- Load 16 words 0x10..0x1F with load_last on the 16th, then force core_pc to 0..15 -> core_inst equals 0x10+pc; prog_valid=1; wptr=0.
- start without any prior load -> stays IDLE; core_rst_n=0; busy=0.
- Load a program, start, stub core_ro sequence 0,1,1,2,3,5,8,13 with res_ready=1 -> FIFO outputs 1,2,3,5,8,13; the repeated 1 and the initial 0 are not pushed; done after 255 cycles.
- res_ready=0, core_ro changes 6 times -> 4 entries held, overflow=1, then drain order matches the first 4 values.
- rst asserted on RUN cycle 10 -> next cycle state IDLE, core_rst_n=0, res_valid=0, prog_valid=0.
- K2_HALT_DETECT_EN: core_pc holds 7 for 2 cycles at cycle 20 -> done=1 and halted=1 by cycle 22; without the macro, done only at cycle 255.
